// File: rtl/fcmp_reduce_if.sv
// fcmp_reduce_if: bundle connecting the fmin/fmax reduction controller to its
// environment.
//   Start side : Flush, Start, StartMax, StartZfa, StartFmt, StartLen
//   Element in : InValid, InReady, InData
//   Comparator : FpuCmpBusy, CmpReq, CmpX, CmpY, CmpOpCtrl, CmpZfa, CmpFmt,
//                CmpFpRes, CmpNV
//   Result out : Busy, ResValid, ResReady, Res, ResNV
// The slave modport is the controller's view; master is the surrounding logic.
interface fcmp_reduce_if #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned FMTBITS = 2,
  parameter int unsigned LENBITS = 8
);

  logic               Flush;
  logic               Start;
  logic               StartMax;
  logic               StartZfa;
  logic [FMTBITS-1:0] StartFmt;
  logic [LENBITS-1:0] StartLen;

  logic               InValid;
  logic               InReady;
  logic [FLEN-1:0]    InData;

  logic               FpuCmpBusy;
  logic               CmpReq;
  logic [FLEN-1:0]    CmpX;
  logic [FLEN-1:0]    CmpY;
  logic [2:0]         CmpOpCtrl;
  logic               CmpZfa;
  logic [FMTBITS-1:0] CmpFmt;
  logic [FLEN-1:0]    CmpFpRes;
  logic               CmpNV;

  logic               Busy;
  logic               ResValid;
  logic               ResReady;
  logic [FLEN-1:0]    Res;
  logic               ResNV;

  modport slave (
    input  Flush, Start, StartMax, StartZfa, StartFmt, StartLen,
    input  InValid, InData,
    output InReady,
    input  FpuCmpBusy, CmpFpRes, CmpNV,
    output CmpReq, CmpX, CmpY, CmpOpCtrl, CmpZfa, CmpFmt,
    input  ResReady,
    output Busy, ResValid, Res, ResNV
  );

  modport master (
    output Flush, Start, StartMax, StartZfa, StartFmt, StartLen,
    output InValid, InData,
    input  InReady,
    output FpuCmpBusy, CmpFpRes, CmpNV,
    input  CmpReq, CmpX, CmpY, CmpOpCtrl, CmpZfa, CmpFmt,
    output ResReady,
    input  Busy, ResValid, Res, ResNV
  );

endinterface

// File: rtl/fcmp_reduce_ctrl.sv
// fcmp_reduce_ctrl: ordered fmin/fmax reduction sequencer sharing the FPU's
// combinational comparator with the scalar pipeline (scalar side has priority).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   io         : fcmp_reduce_if.slave (start command, element stream,
//                comparator drive/return, result handshake)
// The accumulator is compared against each new element (X = acc, Y = element);
// the first element is compared with itself so NaN handling stays uniform.
module fcmp_reduce_ctrl #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned FMTBITS = 2,
  parameter int unsigned LENBITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  fcmp_reduce_if.slave  io
);

  localparam logic [2:0] OP_MIN = 3'b110;
  localparam logic [2:0] OP_MAX = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [FLEN-1:0]    acc;
  logic               nv_acc;
  logic               first;
  logic [LENBITS-1:0] count;
  logic               max_q;
  logic               zfa_q;
  logic [FMTBITS-1:0] fmt_q;
  logic               busy_q;
  logic               res_valid_q;

  logic               run;
  logic               beat;

  // An element is consumed only when the scalar pipeline leaves the comparator free.
  assign run  = (state == RUN);
  assign beat = run & io.InValid & ~io.FpuCmpBusy;

  // Sequencer state, accumulator and registered result-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      nv_acc      <= 1'b0;
      first       <= 1'b0;
      count       <= '0;
      max_q       <= 1'b0;
      zfa_q       <= 1'b0;
      fmt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else if (io.Flush) begin
      state       <= IDLE;
      first       <= 1'b0;
      count       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.Start) begin
            max_q  <= io.StartMax;
            zfa_q  <= io.StartZfa;
            fmt_q  <= io.StartFmt;
            count  <= io.StartLen;
            first  <= 1'b1;
            nv_acc <= 1'b0;
            acc    <= '0;
            busy_q <= 1'b1;
            // An empty reduction reports zero straight away.
            if (io.StartLen != '0) begin
              state <= RUN;
            end else begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (beat) begin
            acc    <= io.CmpFpRes;
            nv_acc <= nv_acc | io.CmpNV;
            first  <= 1'b0;
            count  <= count - LENBITS'(1);
            if (count == LENBITS'(1)) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (io.ResReady) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Comparator drive is same-cycle; operands do not depend on FpuCmpBusy.
  assign io.InReady   = run & ~io.FpuCmpBusy;
  assign io.CmpReq    = beat;
  assign io.CmpX      = first ? io.InData : acc;
  assign io.CmpY      = io.InData;
  assign io.CmpOpCtrl = max_q ? OP_MAX : OP_MIN;
  assign io.CmpZfa    = zfa_q;
  assign io.CmpFmt    = fmt_q;

  assign io.Busy      = busy_q;
  assign io.ResValid  = res_valid_q;
  assign io.Res       = acc;
  assign io.ResNV     = nv_acc;

endmodule

// File: tb/tb_fcmp_reduce_ctrl.sv
// tb_fcmp_reduce_ctrl: directed bench for the fmin/fmax reduction controller.
// A small double-precision comparator model answers the controller's requests;
// expected results are queued at launch and checked by an independent monitor.
module tb_fcmp_reduce_ctrl;

  localparam logic [63:0] CANON = 64'h7FF8000000000000;

  typedef struct packed {
    logic [63:0] res;
    logic        nv;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  fcmp_reduce_if #(.FLEN(64), .FMTBITS(2), .LENBITS(8)) io ();

  fcmp_reduce_ctrl #(.FLEN(64), .FMTBITS(2), .LENBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparator model (double precision) ----------------
  function automatic logic is_nan(input logic [63:0] a);
    return (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
  endfunction

  function automatic logic is_snan(input logic [63:0] a);
    return is_nan(a) && !a[51];
  endfunction

  // Total order with -0 < +0.
  function automatic logic flt(input logic [63:0] a, input logic [63:0] b);
    if (a == b) return 1'b0;
    if (a[63] != b[63]) return a[63];
    if (!a[63]) return a[62:0] < b[62:0];
    return a[62:0] > b[62:0];
  endfunction

  always_comb begin
    logic xn;
    logic yn;
    logic lt;
    xn = is_nan(io.CmpX);
    yn = is_nan(io.CmpY);
    lt = flt(io.CmpX, io.CmpY);
    io.CmpNV = is_snan(io.CmpX) | is_snan(io.CmpY);
    io.CmpFpRes = io.CmpX;
    if ((xn && yn) || (io.CmpZfa && (xn || yn))) io.CmpFpRes = CANON;
    else if (xn) io.CmpFpRes = io.CmpY;
    else if (yn) io.CmpFpRes = io.CmpX;
    else if (io.CmpOpCtrl == 3'b101) io.CmpFpRes = lt ? io.CmpY : io.CmpX;
    else io.CmpFpRes = lt ? io.CmpX : io.CmpY;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- result monitor ----------------
  initial begin
    logic        hold;
    logic [63:0] prev_res;
    logic        prev_nv;
    exp_t        e;
    hold = 1'b0;
    prev_res = '0;
    prev_nv = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (io.ResValid && hold) begin
          chk("res_stable", io.Res, prev_res);
          chk1("resnv_stable", io.ResNV, prev_nv);
        end
        if (io.ResValid && io.ResReady) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got %h expected no result", io.Res);
          end else begin
            e = sb.pop_front();
            chk("res", io.Res, e.res);
            chk1("res_nv", io.ResNV, e.nv);
          end
        end
        hold = io.ResValid && !io.ResReady;
        prev_res = io.Res;
        prev_nv = io.ResNV;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_red(input logic mx, input logic zfa, input logic [7:0] len);
    io.Start    = 1'b1;
    io.StartMax = mx;
    io.StartZfa = zfa;
    io.StartFmt = 2'b01;
    io.StartLen = len;
    tick();
    io.Start    = 1'b0;
  endtask

  task automatic send(input logic [63:0] data);
    io.InValid = 1'b1;
    io.InData  = data;
    @(negedge clk);
    chk1("in_ready", io.InReady, 1'b1);
    chk1("cmp_req", io.CmpReq, 1'b1);
    @(posedge clk);
    #1;
    io.InValid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((io.ResValid || io.Busy) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    io.Flush    = 1'b0;
    io.Start    = 1'b0;
    io.StartMax = 1'b0;
    io.StartZfa = 1'b0;
    io.StartFmt = 2'b01;
    io.StartLen = 8'd0;
    io.InValid  = 1'b1;
    io.InData   = 64'h3FF0000000000000;
    io.FpuCmpBusy = 1'b0;
    io.ResReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", io.Busy, 1'b0);
    chk1("rst_res_valid", io.ResValid, 1'b0);
    chk1("rst_in_ready", io.InReady, 1'b0);
    chk1("rst_cmp_req", io.CmpReq, 1'b0);
    chk("rst_res", io.Res, 64'd0);
    chk1("rst_res_nv", io.ResNV, 1'b0);
    reset = 1'b0;
    io.InValid = 1'b0;
    tick();

    // Max of three doubles, back to back.
    start_red(1'b1, 1'b0, 8'd3);
    sb.push_back('{res: 64'h400C000000000000, nv: 1'b0});
    chk("opctrl_max", 64'(io.CmpOpCtrl), 64'(3'b101));
    send(64'h3FF0000000000000);
    send(64'hC000000000000000);
    chk1("t1_rv_early", io.ResValid, 1'b0);
    send(64'h400C000000000000);
    chk1("t1_rv_after_last", io.ResValid, 1'b1);
    wait_idle();

    // Min with a quiet NaN first element (non-Zfa).
    start_red(1'b0, 1'b0, 8'd2);
    sb.push_back('{res: 64'h4000000000000000, nv: 1'b0});
    chk("opctrl_min", 64'(io.CmpOpCtrl), 64'(3'b110));
    send(64'h7FF8000000000000);
    send(64'h4000000000000000);
    wait_idle();

    // Zfa min with a signalling NaN in the middle.
    start_red(1'b0, 1'b1, 8'd3);
    sb.push_back('{res: CANON, nv: 1'b1});
    chk1("cmp_zfa", io.CmpZfa, 1'b1);
    send(64'h3FF0000000000000);
    send(64'h7FF0000000000001);
    send(64'hBFF0000000000000);
    wait_idle();

    // Two-cycle comparator steal mid-run.
    start_red(1'b1, 1'b0, 8'd2);
    sb.push_back('{res: 64'h4000000000000000, nv: 1'b0});
    send(64'h3FF0000000000000);
    io.FpuCmpBusy = 1'b1;
    io.InValid    = 1'b1;
    io.InData     = 64'h4000000000000000;
    repeat (2) begin
      @(negedge clk);
      chk1("stall_in_ready", io.InReady, 1'b0);
      chk1("stall_cmp_req", io.CmpReq, 1'b0);
      chk("stall_acc_held", io.CmpX, 64'h3FF0000000000000);
      chk1("stall_rv", io.ResValid, 1'b0);
      @(posedge clk);
      #1;
    end
    io.FpuCmpBusy = 1'b0;
    send(64'h4000000000000000);
    chk1("stall_rv_after_last", io.ResValid, 1'b1);
    wait_idle();

    // Empty reduction, result held under back-pressure while Start is pulsed.
    io.ResReady = 1'b0;
    start_red(1'b0, 1'b0, 8'd0);
    sb.push_back('{res: 64'd0, nv: 1'b0});
    chk1("len0_rv", io.ResValid, 1'b1);
    chk1("len0_busy", io.Busy, 1'b1);
    repeat (5) begin
      io.Start    = 1'b1;
      io.StartLen = 8'd3;
      io.InValid  = 1'b1;
      @(negedge clk);
      chk1("len0_hold_rv", io.ResValid, 1'b1);
      chk("len0_hold_res", io.Res, 64'd0);
      chk1("len0_in_ready", io.InReady, 1'b0);
      @(posedge clk);
      #1;
    end
    io.Start    = 1'b0;
    io.InValid  = 1'b0;
    io.ResReady = 1'b1;
    wait_idle();

    // Flush mid-run drops the reduction; the next one runs cleanly.
    start_red(1'b0, 1'b0, 8'd4);
    send(64'h3FF0000000000000);
    io.Flush = 1'b1;
    tick();
    io.Flush = 1'b0;
    chk1("flush_busy", io.Busy, 1'b0);
    chk1("flush_rv", io.ResValid, 1'b0);
    tick();
    chk1("flush_rv_later", io.ResValid, 1'b0);
    start_red(1'b0, 1'b0, 8'd1);
    sb.push_back('{res: 64'hC000000000000000, nv: 1'b0});
    send(64'hC000000000000000);
    chk1("after_flush_rv", io.ResValid, 1'b1);
    wait_idle();

    repeat (3) tick();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcmp_reduce_ctrl.md
Name: fcmp_reduce_ctrl

Overview:
- Sequencer that computes an ordered fmin/fmax reduction over a stream of FP elements.
- Time-shares the FPU's single combinational comparison unit with the scalar FPU pipeline; the scalar pipeline always has priority.
- Drives the comparator operands and OpCtrl, accumulates the running result and the invalid flag, and returns one result per reduction through a valid/ready handshake.
- Sits beside the FPU for reduction and vector-assist operations.

Parameters:
- FLEN, 64, FP register width; operand and result width.
- FMTBITS, 2, width of the format field passed to the comparator.
- LENBITS, 8, width of the element-count field (max 2^LENBITS-1 elements).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Flush  in  1  synchronous abort to IDLE; result discarded
- Start  in  1  begin reduction; honoured only in IDLE
- StartMax  in  1  0 = min, 1 = max
- StartZfa  in  1  1 = fminm/fmaxm (NaN-propagating)
- StartFmt  in  FMTBITS  element format
- StartLen  in  LENBITS  element count
- InValid  in  1  element available
- InReady  out  1  element accepted when InValid & InReady
- InData  in  FLEN  element (NaN-boxed as in the register file)
- FpuCmpBusy  in  1  scalar pipeline owns the comparator this cycle
- CmpReq  out  1  controller uses the comparator this cycle
- CmpX, CmpY  out  FLEN  comparator operands
- CmpOpCtrl  out  3  110 = min, 101 = max
- CmpZfa  out  1  latched Zfa
- CmpFmt  out  FMTBITS  latched format
- CmpFpRes  in  FLEN  comparator FP result (same cycle)
- CmpNV  in  1  comparator invalid flag (same cycle)
- Busy  out  1  state != IDLE
- ResValid  out  1  result available
- ResReady  in  1  consumer accepts result
- Res  out  FLEN  reduction result
- ResNV  out  1  OR of CmpNV over all accepted beats

Behaviour:
- Reset: state = IDLE; Acc, Res = 0; NVAcc, ResNV = 0; Count = 0; First = 0; InReady, ResValid, CmpReq, Busy = 0.
- Flush has the same effect as reset on control state (state, First, Count, ResValid).
  - Priority: reset > Flush > all other events.
  - Flush in DONE drops the result.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start=1 latches StartMax/Zfa/Fmt/Len; sets Count = StartLen, First = 1, NVAcc = 0.
  - StartLen != 0 → RUN next cycle.
  - StartLen == 0 → DONE next cycle with Acc = 0, NVAcc = 0.
- RUN:
  - InReady = ~FpuCmpBusy; CmpReq = InValid & ~FpuCmpBusy.
  - CmpX = First ? InData : Acc; CmpY = InData.
  - CmpOpCtrl = StartMax ? 101 : 110; operand drive does not depend on FpuCmpBusy.
  - On a beat (InValid & InReady), next cycle:
    - Acc = CmpFpRes; NVAcc |= CmpNV; First = 0; Count = Count - 1.
    - If Count was 1 → DONE.
  - The first beat compares the element with itself. A NaN first element therefore becomes the canonical NaN and sets NV only if it is signalling, and the comparator's NaN rules apply uniformly.
  - No beat → all state holds.
  - FpuCmpBusy stalls indefinitely without loss.
  - Start is ignored.
- DONE:
  - ResValid = 1; Res = Acc; ResNV = NVAcc; InReady = 0.
  - Res and ResNV are stable while ResValid & ~ResReady.
  - ResValid & ResReady → IDLE next cycle, ResValid = 0.
  - Start is ignored in DONE; a new Start is accepted in IDLE one cycle after the handshake.
- Latency: one beat per cycle with no stalls. ResValid rises the cycle after the last beat, so a stall-free N-element reduction costs N+1 cycles from the first beat.
- ±0 ordering, equal operands and NaN selection are the comparator's; the controller only fixes operand order as X = accumulator, Y = new element.

Test Plan:
- Max, Fmt = double, Len = 3, elements 3FF0000000000000, C000000000000000, 400C000000000000 back-to-back → Res = 400C000000000000, ResNV = 0, ResValid the cycle after the 3rd beat.
- Min, Zfa = 0, Len = 2, elements 7FF8000000000000 then 4000000000000000 → Res = 4000000000000000, ResNV = 0.
- Min, Zfa = 1, Len = 3, elements 3FF0000000000000, 7FF0000000000001, BFF0000000000000 → Res = 7FF8000000000000, ResNV = 1.
- Max, Len = 2, FpuCmpBusy = 1 for 2 cycles mid-RUN with InValid = 1 → InReady = 0, CmpReq = 0, Acc unchanged during the stall; completion delayed exactly 2 cycles.
- Len = 0 → ResValid the cycle after Start with Res = 0, ResNV = 0; hold ResReady = 0 for 5 cycles while pulsing Start → ResValid stays 1, Res stable, Start ignored.
- Len = 4, Flush after the 1st beat → IDLE next cycle, Busy = 0, no ResValid; a following Start with Len = 1, element C000000000000000 → Res = C000000000000000.
